// File: rtl/fp_square_pkg.sv
// Shared binary32 constants, FSM state and operand-class encodings for the
// iterative single-precision squarer.
package fp_square_pkg;

    localparam int unsigned EXP_W   = 8;
    localparam int unsigned FRAC_W  = 23;
    localparam int unsigned SIG_W   = 24;            // significand incl. hidden bit
    localparam int unsigned PROD_W  = 2 * SIG_W;
    localparam int unsigned BIAS    = 127;
    localparam int unsigned EXP_MAX = 255;

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] PINF  = 32'h7F80_0000;
    localparam logic [31:0] PZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StUnpack = 3'd1,
        StMul    = 3'd2,
        StRound  = 3'd3,
        StDone   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ClsNormal = 2'd0,
        ClsZero   = 2'd1,   // zero or subnormal, both flushed
        ClsInf    = 2'd2,
        ClsNan    = 2'd3
    } class_e;

    // Classify a binary32 operand from its exponent and fraction fields.
    function automatic class_e classify(input logic [EXP_W-1:0]  exp_f,
                                        input logic [FRAC_W-1:0] frac_f);
        if (exp_f == EXP_W'(EXP_MAX)) begin
            return (frac_f != '0) ? ClsNan : ClsInf;
        end
        if (exp_f == '0) begin
            return ClsZero;
        end
        return ClsNormal;
    endfunction

endpackage

// File: rtl/fp_square_seq_mul24.sv
// Iterative unsigned 24x24 shift-add multiplier. A start pulse loads the
// operands; one multiplier bit is consumed per clock for 24 clocks. done_o is
// high during the last iteration cycle, product_o is final after that edge
// and held until the next start.
module seq_mul24
    import fp_square_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [SIG_W-1:0]  a_i,
    input  logic [SIG_W-1:0]  b_i,
    output logic              done_o,
    output logic [PROD_W-1:0] product_o
);

    localparam logic [4:0] LastCnt = 5'(SIG_W - 1);

    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [SIG_W-1:0]  mplier_q, mplier_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              run_q, run_d;

    // Load on start, otherwise add the shifted multiplicand for each set bit.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start_i) begin
            acc_d    = '0;
            mcand_d  = {{SIG_W{1'b0}}, a_i};
            mplier_d = b_i;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = {mcand_q[PROD_W-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[SIG_W-1:1]};
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == LastCnt) begin
                run_d = 1'b0;
            end
        end
    end

    // Multiplier state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

    assign done_o    = run_q && (cnt_q == LastCnt);
    assign product_o = acc_q;

endmodule

// File: rtl/fp_square.sv
// Multi-cycle binary32 squarer, data_o = data_i * data_i, with a fixed
// 27-clock latency from capture to the done pulse for every input.
// Sequence: IDLE -> UNPACK -> MUL (24 clocks) -> ROUND -> DONE -> IDLE.
module fp_square
    import fp_square_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned MANT_W    = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATAWIDTH-1:0] data_i,
    output logic [DATAWIDTH-1:0] data_o,
    output logic                 done,
    output logic                 busy
);

    state_e                state_q, state_d;
    logic [DATAWIDTH-1:0]  operand_q, operand_d;
    logic [EXP_W-1:0]      exp_q, exp_d;
    class_e                cls_q, cls_d;
    logic [31:0]           result_q, result_d;
    logic [DATAWIDTH-1:0]  data_q, data_d;
    logic                  done_q, done_d;

    logic [EXP_W-1:0]      op_exp;
    logic [FRAC_W-1:0]     op_frac;
    logic [MANT_W-1:0]     op_mant;
    logic                  mul_start;
    logic                  mul_done;
    logic [PROD_W-1:0]     product;

    logic                  p_hi;
    logic [FRAC_W-1:0]     mant_pre;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic [FRAC_W:0]       mant_sum;
    logic signed [10:0]    e_base;
    logic signed [10:0]    e_r;
    logic [31:0]           round_res;

    // A square is never negative, so the sign is dropped; P[46] is only the
    // hidden bit of an unshifted product and carries no rounding information.
    logic unused_sign;
    logic unused_hidden;
    assign unused_sign   = operand_q[DATAWIDTH-1];
    assign unused_hidden = product[PROD_W-2];

    assign op_exp    = operand_q[30:23];
    assign op_frac   = operand_q[22:0];
    assign op_mant   = {(op_exp != '0), op_frac};
    assign mul_start = (state_q == StUnpack);

    seq_mul24 u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (op_mant),
        .b_i       (op_mant),
        .done_o    (mul_done),
        .product_o (product)
    );

    // Normalise the product, round to nearest even and apply special cases.
    always_comb begin
        p_hi = product[PROD_W-1];
        if (p_hi) begin
            mant_pre = product[46:24];
            guard    = product[23];
            sticky   = |product[22:0];
        end else begin
            mant_pre = product[45:23];
            guard    = product[22];
            sticky   = |product[21:0];
        end
        round_up = guard & (sticky | mant_pre[0]);
        mant_sum = {1'b0, mant_pre} + {{FRAC_W{1'b0}}, round_up};

        // Unbiased-then-rebiased exponent: 2*e_in - BIAS, +1 on a 2.x product.
        e_base = $signed({3'b000, exp_q}) + $signed({3'b000, exp_q})
               - $signed(11'(BIAS)) + $signed({10'b0, p_hi});
        // A rounding carry leaves mant_sum[22:0] all zero and bumps the exponent.
        e_r    = e_base + $signed({10'b0, mant_sum[FRAC_W]});

        round_res = PZERO;
        unique case (cls_q)
            ClsNan:  round_res = QNAN;
            ClsInf:  round_res = PINF;
            ClsZero: round_res = PZERO;
            default: begin
                if (e_r > $signed(11'(EXP_MAX - 1))) begin
                    round_res = PINF;
                end else if (e_r < 11'sd1) begin
                    round_res = PZERO;
                end else begin
                    round_res = {1'b0, e_r[7:0], mant_sum[FRAC_W-1:0]};
                end
            end
        endcase
    end

    // Sequencer next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        exp_d     = exp_q;
        cls_d     = cls_q;
        result_d  = result_q;
        data_d    = data_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    operand_d = data_i;
                    state_d   = StUnpack;
                end
            end
            StUnpack: begin
                exp_d   = op_exp;
                cls_d   = classify(op_exp, op_frac);
                state_d = StMul;
            end
            StMul: begin
                if (mul_done) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                result_d = round_res;
                state_d  = StDone;
            end
            StDone: begin
                data_d  = result_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any op without a done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            operand_q <= '0;
            exp_q     <= '0;
            cls_q     <= ClsNormal;
            result_q  <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            exp_q     <= exp_d;
            cls_q     <= cls_d;
            result_q  <= result_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign data_o = data_q;
    assign done   = done_q;
    // The done cycle is already back in IDLE but still counts as busy.
    assign busy   = (state_q != StIdle) | done_q;

endmodule

// File: tb/tb_fp_square.sv
// Scoreboard bench for fp_square: the driver pushes the expected result and
// the cycle its done pulse must appear; a monitor pops on every done.
module tb_fp_square;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        done;
    logic        busy;

    fp_square #(
        .DATAWIDTH (32),
        .MANT_W    (24)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data_i (data_i),
        .data_o (data_o),
        .done   (done),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] exp;
        int          tol;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int n);
        real r = 1.0;
        if (n >= 0) begin
            repeat (n) r = r * 2.0;
        end else begin
            repeat (-n) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real fp_to_real(input logic [31:0] x);
        int e = int'(x[30:23]);
        int f = int'(x[22:0]);
        return (8388608.0 + real'(f)) * pow2(e - 150);
    endfunction

    // Round a positive real to binary32, RNE, overflow to +Inf, flush below normal.
    function automatic logic [31:0] to_fp32(input real v_in);
        real         v = v_in;
        real         fl;
        real         diff;
        int          e = 0;
        int          mi;
        int          b;
        logic [31:0] mbits;
        logic [31:0] bbits;
        if (v == 0.0) return 32'h0;
        while (v >= 16777216.0) begin v = v / 2.0; e++; end
        while (v < 8388608.0)   begin v = v * 2.0; e--; end
        fl   = $floor(v);
        diff = v - fl;
        mi   = int'(fl);
        if (diff > 0.5 || (diff == 0.5 && (mi % 2) == 1)) mi++;
        if (mi == 16777216) begin mi = 8388608; e++; end
        b = e + 150;
        if (b > 254) return 32'h7F80_0000;
        if (b < 1)   return 32'h0;
        mbits = mi;
        bbits = b;
        return {1'b0, bbits[7:0], mbits[22:0]};
    endfunction

    function automatic logic [31:0] model_square(input logic [31:0] x);
        real a;
        if (x[30:23] == 8'hFF) return (x[22:0] != 0) ? 32'h7FC0_0000 : 32'h7F80_0000;
        if (x[30:23] == 8'h00) return 32'h0;
        a = fp_to_real(x);
        return to_fp32(a * a);
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: actual data_o=%h required no done",
                         cyc, data_o);
            end else begin
                mon_e = sbq.pop_front();
                check("latency", cyc, mon_e.due);
                if (mon_e.tol == 0) begin
                    check("data", data_o, mon_e.exp);
                end else begin
                    checks++;
                    if ((int'(data_o) - int'(mon_e.exp) > mon_e.tol) ||
                        (int'(mon_e.exp) - int'(data_o) > mon_e.tol)) begin
                        errors++;
                        $display("FAIL roundtrip at cycle %0d: actual=%h required=%h +/-%0d ulp",
                                 cyc, data_o, mon_e.exp, mon_e.tol);
                    end
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] x, input logic [31:0] exp_v, input int tol);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        data_i = x;
        e.exp  = exp_v;
        e.tol  = tol;
        e.due  = cyc + 28;
        sbq.push_back(e);
        @(negedge clk);
        start  = 1'b0;
        data_i = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL timeout: actual %0d results pending required 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic sq(input logic [31:0] x);
        issue(x, model_square(x), 0);
        drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] x;
    logic [31:0] s;
    int          c0;
    int          ex;
    exp_t        e2;

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        data_i = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_data", data_o, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        rst = 1'b0;

        // Directed values with constant expectations.
        issue(32'h4040_0000, 32'h4110_0000, 0); drain();
        issue(32'hC000_0000, 32'h4080_0000, 0); drain();
        issue(32'h3FC0_0000, 32'h4010_0000, 0); drain();
        issue(32'h3F80_0001, 32'h3F80_0002, 0); drain();
        issue(32'h7FC0_0001, 32'h7FC0_0000, 0); drain();
        issue(32'hFF80_0000, 32'h7F80_0000, 0); drain();
        issue(32'h0000_0001, 32'h0000_0000, 0); drain();
        issue(32'h7F00_0000, 32'h7F80_0000, 0); drain();
        issue(32'h4040_0000, 32'h4110_0000, 0); drain();
        issue(32'h1F00_0000, 32'h0000_0000, 0); drain();

        // Busy profile across one op: high from the cycle after capture through done.
        @(negedge clk);
        c0     = cyc;
        start  = 1'b1;
        data_i = 32'h4000_0000;
        e2.exp = 32'h4080_0000; e2.tol = 0; e2.due = c0 + 28;
        sbq.push_back(e2);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("busy_profile", {31'b0, busy}, {31'b0, (cyc >= c0 + 1 && cyc <= c0 + 28)});
        end
        drain();

        // Start held 3 clocks: one op only.
        @(negedge clk);
        start  = 1'b1;
        data_i = 32'h4040_0000;
        e2.exp = 32'h4110_0000; e2.tol = 0; e2.due = cyc + 28;
        sbq.push_back(e2);
        repeat (3) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Start held 56 clocks: back-to-back ops, dones 28 clocks apart.
        @(negedge clk);
        c0     = cyc;
        start  = 1'b1;
        data_i = 32'h3FC0_0000;
        e2.exp = 32'h4010_0000; e2.tol = 0; e2.due = c0 + 28;
        sbq.push_back(e2);
        e2.exp = 32'h3F80_0002; e2.tol = 0; e2.due = c0 + 56;
        sbq.push_back(e2);
        @(negedge clk);
        data_i = 32'h3F80_0001;
        repeat (55) @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);

        // Reset at E10 of an op: no done, outputs cleared the next cycle.
        @(negedge clk);
        c0     = cyc;
        start  = 1'b1;
        data_i = 32'h4040_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_data", data_o, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'hC000_0000, 32'h4080_0000, 0); drain();

        // Random normals: half in a range that stays normal, half across all exponents.
        for (int i = 0; i < 1000; i++) begin
            ex = (i % 2 == 0) ? int'($urandom_range(64, 190)) : int'($urandom_range(1, 254));
            x  = {1'($urandom), 8'(ex), 23'($urandom)};
            sq(x);
        end

        // Square-root round trip. Mantissa kept below 1.375 so squaring the
        // correctly rounded root is provably within one ulp of x.
        for (int i = 0; i < 100; i++) begin
            ex = int'($urandom_range(2, 253));
            x  = {1'b0, 8'(ex), 23'($urandom_range(0, 32'h2F_FFFF))};
            s  = to_fp32($sqrt(fp_to_real(x)));
            issue(s, x, 1);
            drain();
        end

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sbq.size(), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
